// File: rtl/seg_pkg.sv
// Shared definitions for the six-digit seven-segment scan driver.
// Holds the digit count, the hex segment patterns ({a,b,c,d,e,f,g}, active-high),
// the hex7seg decode function and the frame data record used for staging/shadow.
package seg_pkg;

  localparam int unsigned NUM_DIG = 6;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;

  // One displayed frame: per-digit code, decimal point and blank.
  typedef struct packed {
    logic [NUM_DIG-1:0][3:0] digits;
    logic [NUM_DIG-1:0]      dp;
    logic [NUM_DIG-1:0]      blank;
  } frame_t;

  // Reset content: every digit blanked so nothing shows until the first load.
  localparam frame_t FRAME_RST = '{digits: '0, dp: '0, blank: 6'h3F};

  function automatic logic [6:0] hex7seg(input logic [3:0] code);
    logic [6:0] seg;
    unique case (code)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_scan_drv_if.sv
// Bus between the upstream counter datapath and the scan driver.
// i_digits/i_dp/i_blank/i_load : frame data and one-cycle load strobe (master -> slave)
// o_seg_enb/o_seg_dp/o_seg/o_frame : board pins and frame pulse (slave -> master)
interface seg_scan_drv_if;
  logic [23:0] i_digits;
  logic [5:0]  i_dp;
  logic [5:0]  i_blank;
  logic        i_load;
  logic [5:0]  o_seg_enb;
  logic        o_seg_dp;
  logic [6:0]  o_seg;
  logic        o_frame;

  modport master (
    output i_digits, i_dp, i_blank, i_load,
    input  o_seg_enb, o_seg_dp, o_seg, o_frame
  );

  modport slave (
    input  i_digits, i_dp, i_blank, i_load,
    output o_seg_enb, o_seg_dp, o_seg, o_frame
  );
endinterface

// File: rtl/seg_dec.sv
// Combinational hex to seven-segment decoder.
// code : 4-bit digit code
// seg  : {a,b,c,d,e,f,g}, active-high
module seg_dec
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  assign seg = hex7seg(code);

endmodule

// File: rtl/seg_scan_drv.sv
// Time-multiplexed scan driver for a six-digit seven-segment display.
// Loads land in a staging register and are promoted to the displayed shadow only at the
// frame wrap, so a frame never tears. Pins are registered one cycle after (idx, cnt).
// clk, rst : clock and asynchronous active-high reset
// bus      : seg_scan_drv_if slave (frame data in, segment/enable/frame pins out)
module seg_scan_drv
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned GUARD    = 4
) (
  input logic           clk,
  input logic           rst,
  seg_scan_drv_if.slave bus
);

  localparam int unsigned CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  frame_t        stg_q, stg_d;
  frame_t        shd_q, shd_d;
  frame_t        in_frame;
  logic          pend_q, pend_d;
  logic          wrap_q;
  logic          slot_end, wrap, in_guard;
  logic [6:0]    dec_seg;

  logic [5:0]    enb_q, enb_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_q;

  assign slot_end = (cnt_q == CW'(SCAN_DIV - 1));
  assign wrap     = slot_end && (idx_q == 3'(NUM_DIG - 1));
  assign in_guard = (32'(cnt_q) < GUARD);
  assign in_frame = '{digits: bus.i_digits, dp: bus.i_dp, blank: bus.i_blank};

  seg_dec u_dec (
    .code(shd_q.digits[idx_q]),
    .seg (dec_seg)
  );

  always_comb begin
    cnt_d  = slot_end ? '0 : cnt_q + 1'b1;
    idx_d  = idx_q;
    stg_d  = stg_q;
    shd_d  = shd_q;
    pend_d = pend_q;

    if (slot_end) begin
      idx_d = (idx_q == 3'(NUM_DIG - 1)) ? 3'd0 : idx_q + 3'd1;
    end

    if (bus.i_load) begin
      stg_d  = in_frame;
      pend_d = 1'b1;
    end

    // A load on the wrap cycle bypasses staging so it shows in the very next frame.
    if (wrap) begin
      if (bus.i_load) begin
        shd_d  = in_frame;
        pend_d = 1'b0;
      end else if (pend_q) begin
        shd_d  = stg_q;
        pend_d = 1'b0;
      end
    end
  end

  always_comb begin
    enb_d = ~(6'b000001 << idx_q);
    seg_d = (in_guard || shd_q.blank[idx_q]) ? 7'd0 : dec_seg;
    dp_d  = shd_q.dp[idx_q] && !in_guard;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      stg_q   <= FRAME_RST;
      shd_q   <= FRAME_RST;
      pend_q  <= 1'b0;
      wrap_q  <= 1'b0;
      enb_q   <= 6'h3F;
      seg_q   <= 7'd0;
      dp_q    <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stg_q   <= stg_d;
      shd_q   <= shd_d;
      pend_q  <= pend_d;
      // Delayed one extra cycle so the pulse lines up with slot 0's first output cycle.
      wrap_q  <= wrap;
      enb_q   <= enb_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= wrap_q;
    end
  end

  assign bus.o_seg_enb = enb_q;
  assign bus.o_seg     = seg_q;
  assign bus.o_seg_dp  = dp_q;
  assign bus.o_frame   = frame_q;

endmodule

// File: tb/tb_seg_scan_drv.sv
// Self-checking bench for seg_scan_drv with SCAN_DIV=4, GUARD=1.
// A time-indexed frame model predicts every pin on every cycle; directed sequences and a
// hex decode table add fixed expectations for the load/frame corner cases.
module tb_seg_scan_drv;
  import seg_pkg::*;

  localparam int unsigned SD = 4;
  localparam int unsigned GD = 1;
  localparam int unsigned FR = 6 * SD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_drv_if bus ();

  seg_scan_drv #(
    .SCAN_DIV(SD),
    .GUARD   (GD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [3:0] code;
    logic [6:0] seg;
  } hex_vec_t;

  hex_vec_t   tbl [16];
  logic [6:0] lut [16];

  int vectors     = 0;
  int miscompares = 0;

  // Model: n counts states since reset release; m_* is what is on display, s_* is staged.
  int          n;
  logic [23:0] m_dig, s_dig;
  logic [5:0]  m_dp, m_blank, s_dp, s_blank;
  bit          s_pend;

  logic [5:0]  cap_enb [FR];
  logic [6:0]  cap_seg [FR];
  logic        cap_dp  [FR];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    n       = 0;
    m_dig   = '0;
    m_dp    = '0;
    m_blank = 6'h3F;
    s_dig   = '0;
    s_dp    = '0;
    s_blank = 6'h3F;
    s_pend  = 1'b0;
  endtask

  // One clock: predict the pins from the current model state, advance the model, check.
  task automatic tick();
    int         slot;
    int         pos;
    logic [5:0] one;
    logic [5:0] e_enb;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_frame;
    slot    = (n / SD) % 6;
    pos     = n % SD;
    one     = 6'b000001;
    e_enb   = ~(one << slot);
    e_seg   = (pos < GD || m_blank[slot]) ? 7'd0 : lut[m_dig[4*slot +: 4]];
    e_dp    = m_dp[slot] && (pos >= GD);
    e_frame = (n > 0) && (n % FR == 0);
    if (n % FR == FR - 1) begin
      if (bus.i_load) begin
        m_dig   = bus.i_digits;
        m_dp    = bus.i_dp;
        m_blank = bus.i_blank;
        s_pend  = 1'b0;
      end else if (s_pend) begin
        m_dig   = s_dig;
        m_dp    = s_dp;
        m_blank = s_blank;
        s_pend  = 1'b0;
      end
    end else if (bus.i_load) begin
      s_dig   = bus.i_digits;
      s_dp    = bus.i_dp;
      s_blank = bus.i_blank;
      s_pend  = 1'b1;
    end
    n++;
    @(posedge clk);
    #1;
    chk("model_enb", 32'(bus.o_seg_enb), 32'(e_enb));
    chk("model_seg", 32'(bus.o_seg), 32'(e_seg));
    chk("model_dp", 32'(bus.o_seg_dp), 32'(e_dp));
    chk("model_frame", 32'(bus.o_frame), 32'(e_frame));
  endtask

  task automatic load1(input logic [23:0] d, input logic [5:0] dp, input logic [5:0] blank);
    bus.i_digits = d;
    bus.i_dp     = dp;
    bus.i_blank  = blank;
    bus.i_load   = 1'b1;
    tick();
    bus.i_load   = 1'b0;
  endtask

  // Ticks until o_frame is seen; lat returns the number of ticks taken.
  task automatic wait_frame(output int lat);
    bit found;
    found = 1'b0;
    lat   = 0;
    for (int k = 0; k < FR + 2 && !found; k++) begin
      tick();
      lat++;
      if (bus.o_frame) found = 1'b1;
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_timeout: got no o_frame, expected one within %0d cycles", FR + 2);
    end
  endtask

  // Called with pins showing frame position 0; captures positions 0..FR-1.
  // A load at position j is presented while the DUT is in that (idx, cnt) state.
  task automatic cap_frame(input int l1, input logic [23:0] d1, input int l2,
                           input logic [23:0] d2);
    cap_enb[0] = bus.o_seg_enb;
    cap_seg[0] = bus.o_seg;
    cap_dp[0]  = bus.o_seg_dp;
    for (int j = 1; j < FR; j++) begin
      bus.i_dp    = 6'd0;
      bus.i_blank = 6'd0;
      bus.i_load  = (j == l1) || (j == l2);
      bus.i_digits = (j == l1) ? d1 : d2;
      tick();
      cap_enb[j] = bus.o_seg_enb;
      cap_seg[j] = bus.o_seg;
      cap_dp[j]  = bus.o_seg_dp;
    end
    bus.i_load = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;

    tbl[0]  = '{4'h0, 7'b1111110};
    tbl[1]  = '{4'h1, 7'b0110000};
    tbl[2]  = '{4'h2, 7'b1101101};
    tbl[3]  = '{4'h3, 7'b1111001};
    tbl[4]  = '{4'h4, 7'b0110011};
    tbl[5]  = '{4'h5, 7'b1011011};
    tbl[6]  = '{4'h6, 7'b1011111};
    tbl[7]  = '{4'h7, 7'b1110000};
    tbl[8]  = '{4'h8, 7'b1111111};
    tbl[9]  = '{4'h9, 7'b1111011};
    tbl[10] = '{4'hA, 7'b1110111};
    tbl[11] = '{4'hB, 7'b0011111};
    tbl[12] = '{4'hC, 7'b1001110};
    tbl[13] = '{4'hD, 7'b0111101};
    tbl[14] = '{4'hE, 7'b1001111};
    tbl[15] = '{4'hF, 7'b1000111};
    for (int i = 0; i < 16; i++) lut[tbl[i].code] = tbl[i].seg;

    bus.i_load   = 1'b0;
    bus.i_digits = '0;
    bus.i_dp     = '0;
    bus.i_blank  = '0;
    model_reset();

    // Reset held three cycles, then first slot and first frame timing.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_enb", 32'(bus.o_seg_enb), 32'h3F);
    chk("rst_seg", 32'(bus.o_seg), 32'h0);
    chk("rst_dp", 32'(bus.o_seg_dp), 32'h0);
    chk("rst_frame", 32'(bus.o_frame), 32'h0);
    rst = 1'b0;
    model_reset();
    tick();
    chk("first_enb", 32'(bus.o_seg_enb), 32'b111110);
    chk("first_seg", 32'(bus.o_seg), 32'h0);
    wait_frame(lat);
    chk("first_frame_lat", 32'(lat), 32'd24);

    // Basic load, slot 2 guard then digit 2 with dp, slot 5 digit 5.
    load1(24'h543210, 6'b000100, 6'b000000);
    wait_frame(lat);
    cap_frame(-1, 24'h0, -1, 24'h0);
    chk("s2_enb", 32'(cap_enb[8]), 32'b111011);
    chk("s2_guard_seg", 32'(cap_seg[8]), 32'h0);
    chk("s2_guard_dp", 32'(cap_dp[8]), 32'h0);
    for (int j = 9; j < 12; j++) begin
      chk($sformatf("s2_seg[%0d]", j), 32'(cap_seg[j]), 32'b1101101);
      chk($sformatf("s2_dp[%0d]", j), 32'(cap_dp[j]), 32'h1);
    end
    chk("s2_slot5", 32'(cap_seg[21]), 32'b1011011);

    // Load during slot 2 must not disturb slots 3..5 of the current frame.
    wait_frame(lat);
    cap_frame(9, 24'hFFFFFF, -1, 24'h0);
    chk("s3_slot1_old", 32'(cap_seg[5]), 32'b0110000);
    chk("s3_slot3_old", 32'(cap_seg[13]), 32'b1111001);
    chk("s3_slot4_old", 32'(cap_seg[17]), 32'b0110011);
    chk("s3_slot5_old", 32'(cap_seg[21]), 32'b1011011);

    // New frame shows F everywhere; two loads inside it, last one wins.
    wait_frame(lat);
    cap_frame(2, 24'h111111, 14, 24'h999999);
    for (int j = 0; j < FR; j++)
      if (j % SD != 0) chk($sformatf("s3_f[%0d]", j), 32'(cap_seg[j]), 32'b1000111);

    // Frame shows only 9; a load on its wrap cycle lands in the very next frame.
    wait_frame(lat);
    cap_frame(FR - 1, 24'h000007, -1, 24'h0);
    for (int j = 0; j < FR; j++)
      if (j % SD != 0) chk($sformatf("s4_nine[%0d]", j), 32'(cap_seg[j]), 32'b1111011);
    wait_frame(lat);
    chk("s5_frame_lat", 32'(lat), 32'd1);
    cap_frame(-1, 24'h0, -1, 24'h0);
    chk("s5_slot0", 32'(cap_seg[1]), 32'b1110000);
    chk("s5_slot1", 32'(cap_seg[5]), 32'b1111110);

    // Hex decode table, one code replicated across all digits per entry.
    for (int i = 0; i < 16; i++) begin
      load1({6{tbl[i].code}}, 6'd0, 6'd0);
      wait_frame(lat);
      tick();
      chk($sformatf("hex_%0h", tbl[i].code), 32'(bus.o_seg), 32'(tbl[i].seg));
    end

    // Randomised loads, checked cycle by cycle against the model.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.i_digits = 24'($urandom);
        bus.i_dp     = 6'($urandom_range(0, 63));
        bus.i_blank  = 6'($urandom_range(0, 63));
        bus.i_load   = 1'b1;
      end else begin
        bus.i_load = 1'b0;
      end
      tick();
    end
    bus.i_load = 1'b0;

    // Asynchronous reset in the middle of slot 3, with a pending load discarded.
    bus.i_digits = 24'h888888;
    bus.i_dp     = 6'h3F;
    bus.i_blank  = 6'h00;
    bus.i_load   = 1'b1;
    wait_frame(lat);
    bus.i_load = 1'b0;
    for (int j = 0; j < 13; j++) tick();
    #2 rst = 1'b1;
    #1;
    chk("s6_enb", 32'(bus.o_seg_enb), 32'h3F);
    chk("s6_seg", 32'(bus.o_seg), 32'h0);
    chk("s6_dp", 32'(bus.o_seg_dp), 32'h0);
    chk("s6_frame", 32'(bus.o_frame), 32'h0);
    @(posedge clk);
    #3 rst = 1'b0;
    model_reset();
    tick();
    chk("s6_first_enb", 32'(bus.o_seg_enb), 32'b111110);
    for (int j = 0; j < 2 * FR; j++) begin
      tick();
      chk("s6_blank_seg", 32'(bus.o_seg), 32'h0);
      chk("s6_blank_dp", 32'(bus.o_seg_dp), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
